riscv_load_store_unit: RTL
==========================

Name: riscv_load_store_unit

Overview:
- Multi-cycle load/store unit between the single-cycle RISC-V datapath's memory port and the word-only data RAM.
- Accepts one memory request at a time from the CPU and issues word-aligned RAM accesses.
- Sub-word stores use read-modify-write, because the RAM has no byte enables.
- Aligns and sign/zero-extends load data, and stalls the CPU until the access completes.

Parameters:
- RAM_LATENCY, 1: cycles from ram_readEnable asserted to ram_readData valid; legal range 1..7.
- ADDR_WIDTH, 32: width of the CPU address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU memory request present (load or store); held stable while stall=1.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is illegal.
- req_address  in  ADDR_WIDTH  byte address (the ALU result).
- req_writeData  in  32  store data (rs2); the low bytes are used for B/H.
- stall  out  1  CPU must hold pc and request inputs.
- done  out  1  one-cycle pulse: request complete.
- readData  out  32  extended load result; valid when done=1 on a load.
- fault  out  1  with done: misaligned or illegal funct3; no RAM access was made.
- ram_address  out  32  word-aligned address (req_address with bits [1:0] forced to 0).
- ram_readEnable  out  1  RAM read strobe.
- ram_writeEnable  out  1  RAM write strobe (full word).
- ram_writeData  out  32  word to write.
- ram_readData  in  32  RAM read data.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, captured word=0, readData=0.
  - done=0, fault=0, ram_readEnable=0, ram_writeEnable=0.
  - An access in flight is aborted, with no RAM write after reset assertion.
- States: IDLE, READ, WRITE, DONE.
- stall = (state==READ) | (state==WRITE) | (state==IDLE & req_valid). It is 0 in DONE.
- IDLE, when req_valid:
  - fault condition (H/HU with addr[0]≠0, W with addr[1:0]≠0, or illegal funct3) -> DONE with fault latched 1.
  - load, or B/H store -> READ, counter=0.
  - W store -> WRITE.
- READ:
  - ram_readEnable=1.
  - counter increments each cycle.
  - When counter==RAM_LATENCY-1, ram_readData is captured at that edge. The next state is DONE for a load, or WRITE for a store.
- WRITE (one cycle):
  - ram_writeEnable=1.
  - W store: ram_writeData = req_writeData.
  - B store: the captured word with byte lane addr[1:0] replaced by writeData[7:0].
  - H store: the captured word with halfword lane addr[1] replaced by writeData[15:0].
  - Next state is DONE.
- DONE (one cycle):
  - done=1; fault valid.
  - For a load, readData = the selected lane of the captured word, sign-extended (B, H) or zero-extended (W, BU, HU).
  - Next state is IDLE unconditionally.
  - A new request is sampled in IDLE only, so back-to-back requests take one IDLE cycle between them.
- Latency from the accept edge to done, L = RAM_LATENCY:
  - load: L+1 cycles.
  - W store: 2 cycles.
  - B/H store: L+2 cycles.
  - fault: 1 cycle.
- ram_address is driven from req_address in every state. It is combinational and needs no register because the request is held stable.
- RAM strobes are 0 outside READ and WRITE. A fault never strobes the RAM.
- If req_valid drops mid-operation (a CPU protocol violation), the unit still completes the sequence.
- Writes to the byte lanes not selected by a B/H store are preserved exactly.

Decomposition:
- Shared package holds:
  - funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - state encoding (LSU_IDLE, LSU_READ, LSU_WRITE, LSU_DONE).
- One sub-module, riscv_lsu_lane_align, which is purely combinational. It provides:
  - load lane select and extension.
  - store lane merge.
  - misalignment/illegal detection.

Test Plan:
- Load (RAM_LATENCY=1): word at 0x10 = 0x8899AABB, LB at 0x11 -> stall 1 for 2 cycles, done on cycle 2, readData=0xFFFFFFAA; LBU -> 0x000000AA.
- LH at 0x12 -> readData=0xFFFF8899; LHU -> 0x00008899; LW at 0x10 -> 0x8899AABB.
- SB 0x5A at 0x13 over 0x11223344 -> READ, WRITE with ram_writeData=0x5A223344, done on cycle 3; a subsequent LW returns 0x5A223344.
- SW 0xDEADBEEF at 0x20 -> no read strobe, one write strobe, done on cycle 2.
- Faults: LW at 0x22 and SH at 0x21 -> done on cycle 1 with fault=1, no RAM strobe; funct3=011 -> fault=1.
- Reset mid-operation: rst asserted during the READ of an SB -> all outputs go to 0 immediately, no write strobe, target word unchanged. After release, an LW completes normally.
- Latency sweep: RAM_LATENCY=3 -> LW done on cycle 4, SH done on cycle 5, with exactly one read strobe sequence each.

Source files
------------

// File: rtl/riscv_load_store_unit_pkg.sv
// Shared definitions for the RISC-V load/store unit.
//   - RV32I funct3 size/sign codes for loads and stores
//   - FSM state encoding used by the top-level sequencer
package riscv_load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_READ  = 2'd1,
        LSU_WRITE = 2'd2,
        LSU_DONE  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   funct3       : RV32I size/sign code of the request
//   byte_offset  : address bits [1:0]
//   load_word    : word read from RAM
//   base_word    : previously captured word, background for sub-word stores
//   store_data   : rs2 value of a store
//   load_result  : selected lane of load_word, sign- or zero-extended
//   merged_word  : base_word with the store lane replaced (whole word for W)
//   fault        : misaligned access or illegal funct3
module riscv_lsu_lane_align
    import riscv_load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] load_word,
    input  logic [31:0] base_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_result,
    output logic [31:0] merged_word,
    output logic        fault
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b = load_word[{byte_offset, 3'b000} +: 8];
        lane_h = load_word[{byte_offset[1], 4'b0000} +: 16];

        // Signed lanes widen with sign extension through the size cast.
        case (funct3)
            LSU_B:   load_result = 32'(lane_b);
            LSU_H:   load_result = 32'(lane_h);
            LSU_W:   load_result = load_word;
            LSU_BU:  load_result = {24'b0, lane_b};
            LSU_HU:  load_result = {16'b0, lane_h};
            default: load_result = '0;
        endcase
    end

    // funct3[1:0] carries the access size for both signed and unsigned codes.
    always_comb begin
        merged_word = base_word;
        case (funct3[1:0])
            2'b00:   merged_word[{byte_offset, 3'b000} +: 8]     = store_data[7:0];
            2'b01:   merged_word[{byte_offset[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

    always_comb begin
        case (funct3)
            LSU_B, LSU_BU: fault = 1'b0;
            LSU_H, LSU_HU: fault = byte_offset[0];
            LSU_W:         fault = (byte_offset != 2'b00);
            default:       fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_load_store_unit.sv
// Multi-cycle load/store unit between the CPU memory port and a word-only RAM.
// Sub-word stores are done as read-modify-write since the RAM has no byte
// enables. The CPU is stalled until the access completes.
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : CPU request (held stable while stall=1)
//   stall             : CPU must hold pc and request
//   done              : one-cycle completion pulse
//   readData          : extended load result, valid with done on a load
//   fault             : with done, misaligned/illegal request (no RAM access)
//   ram_*             : word-aligned RAM port
module riscv_load_store_unit
    import riscv_load_store_unit_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_writeData,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           readData,
    output logic                  fault,
    output logic [31:0]           ram_address,
    output logic                  ram_readEnable,
    output logic                  ram_writeEnable,
    output logic [31:0]           ram_writeData,
    input  logic [31:0]           ram_readData
);

    localparam logic [2:0] LAST_COUNT = 3'(RAM_LATENCY - 1);

    lsu_state_e  state;
    logic [2:0]  counter;
    logic [31:0] captured;
    logic [31:0] addr_full;
    logic [31:0] load_result;
    logic [31:0] merged_word;
    logic        align_fault;

    always_comb begin
        addr_full = 32'(req_address);
    end

    riscv_lsu_lane_align u_lane_align (
        .funct3      (req_funct3),
        .byte_offset (addr_full[1:0]),
        .load_word   (ram_readData),
        .base_word   (captured),
        .store_data  (req_writeData),
        .load_result (load_result),
        .merged_word (merged_word),
        .fault       (align_fault)
    );

    // The request is held stable for the whole access, so the RAM address
    // and write data come straight from it without extra registers.
    assign ram_address     = {addr_full[31:2], 2'b00};
    assign ram_writeData   = merged_word;
    assign ram_readEnable  = (state == LSU_READ);
    assign ram_writeEnable = (state == LSU_WRITE);
    assign done            = (state == LSU_DONE);
    assign stall           = (state == LSU_READ) || (state == LSU_WRITE) ||
                             ((state == LSU_IDLE) && req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LSU_IDLE;
            counter  <= '0;
            captured <= '0;
            readData <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        if (align_fault) begin
                            fault <= 1'b1;
                            state <= LSU_DONE;
                        end else if (req_write && (req_funct3 == LSU_W)) begin
                            state <= LSU_WRITE;
                        end else begin
                            counter <= '0;
                            state   <= LSU_READ;
                        end
                    end
                end
                LSU_READ: begin
                    counter <= counter + 3'd1;
                    if (counter == LAST_COUNT) begin
                        captured <= ram_readData;
                        if (req_write) begin
                            state <= LSU_WRITE;
                        end else begin
                            readData <= load_result;
                            state    <= LSU_DONE;
                        end
                    end
                end
                LSU_WRITE: begin
                    state <= LSU_DONE;
                end
                LSU_DONE: begin
                    fault <= 1'b0;
                    state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule
